// File: rtl/comp_flag_gen.sv
// comp_flag_gen: digit-serial magnitude comparator producing the less/eql flag
// pair for comp_dcd. Operands are latched on a start handshake, compared
// DIGIT_W bits per cycle starting at the MSB digit, and the flags are offered
// under a valid/ready handshake.
//
// Optional feature macro: COMP_FLAG_GEN_EARLY_EXIT_EN
//   defined   -> leave CMP as soon as the first differing digit is seen
//   undefined -> always scan all NDIG digits (constant latency)
// Flag values are identical in both builds.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for operands, start_ready=1
// CMP   | scanning digits MSB-first, one digit per cycle
// DONE  | flags valid, waiting for out_ready
module comp_flag_gen #(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             signed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             less_out,
    output logic             eql_out,
    output logic             busy
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands are shifted left each CMP cycle so the active digit is always
    // the top DIGIT_W bits; idx only tracks how many digits remain.
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [IDX_W-1:0]   idx;
    logic               decided;
    logic               dec_less;

    logic [DIGIT_W-1:0] dig_a;
    logic [DIGIT_W-1:0] dig_b;
    logic               dig_lt;
    logic               dig_gt;
    logic               last_dig;
    logic               cmp_end;
    logic               fin_less;
    logic               fin_eql;
    logic               accept;
    logic               handoff;

    assign dig_a    = a_reg[WIDTH-1 -: DIGIT_W];
    assign dig_b    = b_reg[WIDTH-1 -: DIGIT_W];
    assign dig_lt   = (dig_a < dig_b);
    assign dig_gt   = (dig_a > dig_b);
    assign last_dig = (idx == '0);

`ifdef COMP_FLAG_GEN_EARLY_EXIT_EN
    assign cmp_end  = last_dig | dig_lt | dig_gt;
`else
    assign cmp_end  = last_dig;
`endif

    // A decision recorded on an earlier digit wins; otherwise the current
    // digit decides, and all-equal through the last digit means A == B.
    assign fin_less = decided ? dec_less : dig_lt;
    assign fin_eql  = ~decided & ~dig_lt & ~dig_gt;

    assign accept   = (state == IDLE) && start_valid;
    assign handoff  = (state == DONE) && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)   state_nxt = CMP;
            CMP:  if (cmp_end)  state_nxt = DONE;
            DONE: if (handoff)  state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        start_ready = (state == IDLE);
        out_valid   = (state == DONE);
        busy        = (state != IDLE);
    end

    // Operand latch, digit scan and flag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            idx      <= IDX_TOP;
            decided  <= 1'b0;
            dec_less <= 1'b0;
            less_out <= 1'b0;
            eql_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Flipping the sign bit of both operands maps
                        // two's-complement order onto unsigned order.
                        a_reg    <= {a_in[WIDTH-1] ^ signed_in, a_in[WIDTH-2:0]};
                        b_reg    <= {b_in[WIDTH-1] ^ signed_in, b_in[WIDTH-2:0]};
                        idx      <= IDX_TOP;
                        decided  <= 1'b0;
                        dec_less <= 1'b0;
                    end
                end
                CMP: begin
                    a_reg <= a_reg << DIGIT_W;
                    b_reg <= b_reg << DIGIT_W;
                    if (!last_dig) begin
                        idx <= idx - IDX_W'(1);
                    end
                    if (!decided && (dig_lt || dig_gt)) begin
                        decided  <= 1'b1;
                        dec_less <= dig_lt;
                    end
                    if (cmp_end) begin
                        less_out <= fin_less;
                        eql_out  <= fin_eql;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_flag_gen.sv
// Directed bench for comp_flag_gen: a scoreboard queue holds the expected
// flags and latency for every accepted operand pair and is drained when the
// result appears. Latency expectations follow COMP_FLAG_GEN_EARLY_EXIT_EN.
module tb_comp_flag_gen;

    localparam int WIDTH   = 32;
    localparam int DIGIT_W = 4;
    localparam int NDIG    = WIDTH / DIGIT_W;
    localparam int TMO     = 40;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             signed_in;
    logic             out_valid;
    logic             out_ready;
    logic             less_out;
    logic             eql_out;
    logic             busy;

    typedef struct {
        bit less;
        bit eql;
        int lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fails  = 0;
    bit last_less = 0;
    bit last_eql  = 0;

    comp_flag_gen #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .signed_in  (signed_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .less_out   (less_out),
        .eql_out    (eql_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input bit s);
        exp_t e;
        logic [WIDTH-1:0] x;
        e.less = s ? ($signed(a) < $signed(b)) : (a < b);
        e.eql  = (a == b);
        e.lat  = NDIG;
`ifdef COMP_FLAG_GEN_EARLY_EXIT_EN
        x = a ^ b;
        for (int k = NDIG - 1; k >= 0; k--) begin
            if (((x >> (WIDTH - DIGIT_W * (k + 1))) & WIDTH'((1 << DIGIT_W) - 1)) != '0)
                e.lat = k + 1;
        end
`endif
        return e;
    endfunction

    // Present operands at the falling edge; the next rising edge accepts them.
    task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input bit s);
        @(negedge clk);
        a_in        = a;
        b_in        = b;
        signed_in   = s;
        start_valid = 1'b1;
        check("start_ready_idle", start_ready, 1'b1);
        @(posedge clk);
        sb.push_back(model(a, b, s));
        #1;
        start_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid, then check flags.
    task automatic collect();
        exp_t e;
        int   lat;
        bit   got;
        if (sb.size() == 0) begin
            check("sb_empty", 1'b1, 1'b0);
            return;
        end
        e   = sb.pop_front();
        lat = 0;
        got = 0;
        while (!got && lat < TMO) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid === 1'b1) begin
                got = 1;
            end else if (lat < e.lat) begin
                check("busy_cmp", busy, 1'b1);
                check("start_ready_cmp", start_ready, 1'b0);
            end
        end
        check("result_timeout", got, 1'b1);
        check("latency", lat, e.lat);
        check("less_out", less_out, e.less);
        check("eql_out", eql_out, e.eql);
        check("flags_exclusive", less_out & eql_out, 1'b0);
        last_less = e.less;
        last_eql  = e.eql;
    endtask

    // Accept the result; flags must be retained after the return to IDLE.
    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handoff_out_valid", out_valid, 1'b0);
        check("handoff_start_ready", start_ready, 1'b1);
        check("handoff_busy", busy, 1'b0);
        check("retained_less", less_out, last_less);
        check("retained_eql", eql_out, last_eql);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit s);
        drive_start(a, b, s);
        collect();
        handoff();
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        out_ready   = 1'b0;
        a_in        = '0;
        b_in        = '0;
        signed_in   = 1'b0;
        #1;
        check("rst_start_ready", start_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_less", less_out, 1'b0);
        check("rst_eql", eql_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned 5 < 9
        run_op(32'd5, 32'd9, 1'b0);

        // Async reset in the middle of a compare aborts with no result
        drive_start(32'd3, 32'd3, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_start_ready", start_ready, 1'b1);
        check("midrst_less", less_out, 1'b0);
        check("midrst_eql", eql_out, 1'b0);
        check("midrst_busy", busy, 1'b0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("postrst_no_result", out_valid, 1'b0);
        end

        // Signed -1 < 1; the same bits unsigned are greater
        run_op(32'hFFFF_FFFF, 32'd1, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);

        // Equal operands, result held while out_ready stays low
        drive_start(32'h1234_5678, 32'h1234_5678, 1'b0);
        collect();
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_less", less_out, 1'b0);
            check("hold_eql", eql_out, 1'b1);
        end
        handoff();

        // MSB digit differs: early exit latency 1 when enabled, 8 otherwise
        run_op(32'h8000_0000, 32'h0000_0000, 1'b0);
        // Last digit decides
        run_op(32'h0000_0010, 32'h0000_0011, 1'b0);
        // Signed positive vs negative
        run_op(32'h0000_0001, 32'h8000_0000, 1'b1);
        // Middle digit decides, A > B
        run_op(32'h0012_0000, 32'h0011_FFFF, 1'b0);

        // start_valid held high with different operands during CMP/DONE
        @(negedge clk);
        a_in        = 32'h7FFF_FFFF;
        b_in        = 32'h8000_0000;
        signed_in   = 1'b1;
        start_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(32'h7FFF_FFFF, 32'h8000_0000, 1'b1));
        #1;
        a_in      = 32'h0000_0002;
        b_in      = 32'h0000_0002;
        signed_in = 1'b0;
        collect();
        @(posedge clk);
        #1;
        check("held_start_ignored", out_valid, 1'b1);
        handoff();
        // Next edge accepts the operands that were held during the busy phase
        @(posedge clk);
        sb.push_back(model(32'h0000_0002, 32'h0000_0002, 1'b0));
        #1;
        start_valid = 1'b0;
        collect();
        handoff();

        // Remaining signed/unsigned cases covering less, equal and greater
        run_op(32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b1);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        run_op(32'hABCD_0000, 32'hABCD_0001, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
